// File: rtl/image_stream_ctrl_pkg.sv
// Shared types and defaults for the image stream frame sequencer.
// The frame state enum is exported so debug ports and benches can name states.
package image_ctrl_pkg;

  localparam int DIM_WIDTH_DEF  = 12;
  localparam int FCNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/image_stream_ctrl_if.sv
// Stream handshake bundle (valid/ready/data/strb/last) for the image path.
// Handshake rule: a beat transfers on a rising clock edge where valid and
// ready are both high; the master holds data/strb/last stable while valid is
// high and ready is low, and ready may depend combinationally on valid.
interface image_stream_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic                    last;

  modport master (output valid, data, strb, last, input ready);
  modport slave  (input valid, data, strb, last, output ready);
endinterface

// File: rtl/image_pos_counter.sv
// Column/row position within a frame, advanced once per transferred beat.
// line_end marks the last column, frame_end the last column of the last row.
module image_pos_counter #(
  parameter int DIM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  input  logic                 clear,
  input  logic [DIM_WIDTH-1:0] width,
  input  logic [DIM_WIDTH-1:0] height,
  output logic [DIM_WIDTH-1:0] col,
  output logic [DIM_WIDTH-1:0] row,
  output logic                 line_end,
  output logic                 frame_end
);

  assign line_end  = (col == width - 1'b1);
  assign frame_end = line_end && (row == height - 1'b1);

  // Clear wins over advance; col wraps at line end and row steps
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (line_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_stream_ctrl.sv
// image_stream_ctrl: gates stream beats through only while a frame is armed,
// counts position against a latched geometry, regenerates TLAST at frame end
// and flags frames whose upstream TLAST disagrees with that geometry.
// Build option: IMAGE_STREAM_CTRL_LINE_LAST_EN adds a TLAST on every line end.
module image_stream_ctrl
  import image_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
  parameter int FCNT_WIDTH = FCNT_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic                  cfg_continuous,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  abort,
  input  logic                  err_clr,
  image_stream_ctrl_if.slave    s,
  image_stream_ctrl_if.master   m,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_cfg,
  output state_e                dbg_state,
  output logic [DIM_WIDTH-1:0]  dbg_col,
  output logic [DIM_WIDTH-1:0]  dbg_row
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] FLUSH = ST_FLUSH;
  localparam logic [1:0] DONE  = ST_DONE;

`ifdef IMAGE_STREAM_CTRL_LINE_LAST_EN
  localparam bit LINE_LAST = 1'b1;
`else
  localparam bit LINE_LAST = 1'b0;
`endif

  logic [1:0]            state, state_nxt;
  logic [DIM_WIDTH-1:0]  width_q, height_q;
  logic                  cont_q;
  logic                  stop_req;
  logic                  line_end, frame_end;
  logic                  start_ok, cfg_bad;
  logic                  run_xfer, flush_last;
  logic                  cnt_clear;
  logic                  last_gen;
  logic [DATA_WIDTH-1:0] pass_data;

  assign start_ok   = (state == IDLE) && start && (cfg_width != '0) && (cfg_height != '0);
  assign cfg_bad    = (state == IDLE) && start && ((cfg_width == '0) || (cfg_height == '0));
  assign run_xfer   = (state == RUN) && s.valid && m.ready;
  assign flush_last = (state == FLUSH) && s.valid && s.last;
  assign cnt_clear  = start_ok || (state == DONE);
  assign last_gen   = frame_end || (LINE_LAST && line_end);

  image_pos_counter #(.DIM_WIDTH(DIM_WIDTH)) u_pos (
    .clk       (aclk),
    .rst       (areset),
    .advance   (run_xfer),
    .clear     (cnt_clear),
    .width     (width_q),
    .height    (height_q),
    .col       (dbg_col),
    .row       (dbg_row),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Stream routing: pass-through in RUN, sink in FLUSH, closed otherwise
  assign pass_data = s.data;
  assign m.data    = pass_data;
  assign m.strb    = s.strb;
  always_comb begin
    m.valid = 1'b0;
    m.last  = 1'b0;
    s.ready = 1'b0;
    if (state == RUN) begin
      m.valid = s.valid;
      m.last  = last_gen || s.last;
      s.ready = m.ready;
    end else if (state == FLUSH) begin
      s.ready = 1'b1;
    end
  end

  // Next-state decision; abort overrides whatever the beat would have done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN: begin
        if (run_xfer) begin
          if (frame_end)   state_nxt = s.last ? DONE : FLUSH;
          else if (s.last) state_nxt = DONE;
        end
      end
      FLUSH: if (flush_last) state_nxt = DONE;
      DONE:  state_nxt = (cont_q && !stop_req && !stop) ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Geometry and mode are captured once per start so mid-frame edits are safe
  always_ff @(posedge aclk) begin
    if (areset) begin
      width_q  <= '0;
      height_q <= '0;
      cont_q   <= 1'b0;
    end else if (start_ok) begin
      width_q  <= cfg_width;
      height_q <= cfg_height;
      cont_q   <= cfg_continuous;
    end
  end

  // Sticky stop request, only meaningful while a frame sequence is active
  always_ff @(posedge aclk) begin
    if (areset || start_ok || state == IDLE) stop_req <= 1'b0;
    else if (stop)                           stop_req <= 1'b1;
  end

  // Completed-frame counter; an abort landing on DONE does not count
  always_ff @(posedge aclk) begin
    if (areset)                       frame_cnt <= '0;
    else if (state == DONE && !abort) frame_cnt <= frame_cnt + 1'b1;
  end

  // Sticky error flags: a same-cycle set overrides the clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      if (err_clr) begin
        err_short <= 1'b0;
        err_long  <= 1'b0;
        err_cfg   <= 1'b0;
      end
      if (run_xfer && s.last && !frame_end) err_short <= 1'b1;
      if (run_xfer && frame_end && !s.last) err_long  <= 1'b1;
      if (cfg_bad)                          err_cfg   <= 1'b1;
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE) && !abort;
  assign dbg_state  = state_e'(state);

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Bench for image_stream_ctrl: frames are described by width, height and the
// beat index carrying upstream TLAST; expected output beats, flags and counts
// are derived from that description and compared with what the DUT emits.
module tb_image_stream_ctrl;
  import image_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int IW = DW + DW/8 + 1;  // {last, strb, data}

`ifdef IMAGE_STREAM_CTRL_LINE_LAST_EN
  localparam bit TB_LINE_LAST = 1'b1;
`else
  localparam bit TB_LINE_LAST = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [11:0] cfg_width, cfg_height;
  logic        cfg_continuous, start, stop, abort, err_clr;
  logic        busy, frame_done, err_short, err_long, err_cfg;
  logic [15:0] frame_cnt;
  state_e      dbg_state;
  logic [11:0] dbg_col, dbg_row;

  image_stream_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
  image_stream_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  image_stream_ctrl dut (
    .aclk(aclk), .areset(areset),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_continuous(cfg_continuous),
    .start(start), .stop(stop), .abort(abort), .err_clr(err_clr),
    .s(s_if), .m(m_if),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_short(err_short), .err_long(err_long), .err_cfg(err_cfg),
    .dbg_state(dbg_state), .dbg_col(dbg_col), .dbg_row(dbg_row)
  );

  // Clock / reset block
  always #5 aclk = ~aclk;

  int vectors     = 0;
  int miscompares = 0;
  int fc_model    = 0;
  int rdy_mode    = 0;   // 0: always ready, 1: random, 2: toggle every cycle
  int cyc         = 0;
  int done_cnt    = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] got_q[$];
  int            xfer_cyc[$];
  int            done_cyc[$];

  // Downstream ready pattern
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_if.ready = 1'b1;
      1:       m_if.ready = 1'($urandom_range(0, 1));
      default: m_if.ready = ~m_if.ready;
    endcase
  end

  // Monitor: record every downstream transfer and every frame_done pulse
  always @(negedge aclk) begin
    cyc++;
    if (m_if.valid && m_if.ready) begin
      got_q.push_back({m_if.last, m_if.strb, m_if.data});
      xfer_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); xfer_cyc.delete(); done_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // Driver: present one upstream beat and hold it until accepted
  task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] st, input logic l);
    logic hs;
    int   n;
    s_if.valid = 1'b1; s_if.data = d; s_if.strb = st; s_if.last = l;
    n = 0;
    do begin
      @(negedge aclk); hs = s_if.ready;
      @(posedge aclk); #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) begin
      vectors++; miscompares++;
      $display("FAIL send_beat_timeout: beat %h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  // Scenario: one frame of w x h with upstream TLAST on beat k
  task automatic run_frame(input string tag, input int w, input int h, input int k,
                           input int mode, input int gap_max);
    int wh;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] st;
    logic            l;
    wh = w * h;
    rdy_mode = mode;
    clear_sb();
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_continuous = 1'b0;
    pulse_start();
    for (int i = 1; i <= k; i++) begin
      d  = $urandom;
      st = 4'($urandom);
      if (i <= wh) begin
        l = (i == wh) || (i == k) || (TB_LINE_LAST && (i % w == 0));
        exp_q.push_back({l, st, d});
      end
      send_beat(d, st, i == k);
      if (gap_max > 0) begin
        s_if.valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
    s_if.valid = 1'b0;
    wait_idle(tag);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_beat_count: got %0d beats, required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_beat%0d: got %h, required %h", tag, i + 1, got_q[i], exp_q[i]);
      end
    end
    fc_model++;
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_frame_done: %0d pulses, required 1", tag, done_cnt);
    end
    vectors++;
    if (frame_cnt !== 16'(fc_model)) begin
      miscompares++;
      $display("FAIL %s_frame_cnt: got %0d, required %0d", tag, frame_cnt, fc_model);
    end
    vectors++;
    if (err_short !== (k < wh)) begin
      miscompares++;
      $display("FAIL %s_err_short: got %b, required %b", tag, err_short, (k < wh));
    end
    vectors++;
    if (err_long !== (k > wh)) begin
      miscompares++;
      $display("FAIL %s_err_long: got %b, required %b", tag, err_long, (k > wh));
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vectors++;
    if ({err_short, err_long, err_cfg} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_err_clr: flags %b, required 000", tag, {err_short, err_long, err_cfg});
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    d = $urandom;
    areset = 1'b1;
    s_if.valid = 1'b1; s_if.data = d; s_if.strb = 4'hA; s_if.last = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({s_if.ready, m_if.valid, m_if.last, busy, frame_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready/valid/last/busy/done=%b, required 00000",
               {s_if.ready, m_if.valid, m_if.last, busy, frame_done});
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
    vectors++;
    if ({err_short, err_long, err_cfg} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_errs: got %b, required 000", {err_short, err_long, err_cfg});
    end
    vectors++;
    if (m_if.data !== d || m_if.strb !== 4'hA) begin
      miscompares++;
      $display("FAIL reset_data_follow: got %h/%h, required %h/a", m_if.data, m_if.strb, d);
    end
    vectors++;
    if (dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    areset = 1'b0;
    s_if.valid = 1'b0; s_if.last = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    run_frame("single", 4, 2, 8, 0, 0);
  endtask

  task automatic test_short_frame();
    run_frame("short", 4, 2, 5, 0, 0);
  endtask

  task automatic test_long_frame();
    run_frame("long", 4, 2, 11, 0, 0);
  endtask

  task automatic test_random_frames();
    int w, h;
    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 3);
      run_frame("rand", w, h, $urandom_range(1, w * h + 3), 1, 2);
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] d;
    rdy_mode = 0;
    clear_sb();
    cfg_width = 12'd3; cfg_height = 12'd1; cfg_continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 2; f++) begin
      for (int i = 1; i <= 3; i++) begin
        d = $urandom;
        exp_q.push_back({(i == 3), 4'hF, d});
        if (f == 1 && i == 2) stop = 1'b1;
        send_beat(d, 4'hF, i == 3);
        stop = 1'b0;
      end
    end
    cfg_continuous = 1'b0;
    s_if.valid = 1'b0;
    wait_idle("cont");
    s_if.valid = 1'b1;
    repeat (5) tick();
    s_if.valid = 1'b0;
    fc_model += 2;
    vectors++;
    if (done_cnt !== 2) begin
      miscompares++;
      $display("FAIL cont_frames: %0d frame_done pulses, required 2", done_cnt);
    end
    vectors++;
    if (got_q.size() !== 6) begin
      miscompares++;
      $display("FAIL cont_beat_count: got %0d, required 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL cont_beat%0d: got %h, required %h", i + 1, got_q[i], exp_q[i]);
      end
    end
    if (xfer_cyc.size() >= 4 && done_cyc.size() >= 1) begin
      vectors++;
      if (xfer_cyc[3] - xfer_cyc[2] !== 2 || done_cyc[0] !== xfer_cyc[2] + 1) begin
        miscompares++;
        $display("FAIL cont_gap: last=%0d done=%0d next=%0d, required one DONE cycle between",
                 xfer_cyc[2], done_cyc[0], xfer_cyc[3]);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(fc_model)) begin
      miscompares++;
      $display("FAIL cont_frame_cnt: got %0d, required %0d", frame_cnt, fc_model);
    end
  endtask

  task automatic test_cfg_err();
    cfg_width = 12'd0; cfg_height = 12'd2;
    pulse_start();
    vectors++;
    if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_zero_width: err_cfg=%b busy=%b, required 1/0", err_cfg, busy);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vectors++;
    if (err_cfg !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_clr: err_cfg=%b, required 0", err_cfg);
    end
    cfg_width = 12'd3; cfg_height = 12'd0;
    pulse_start();
    vectors++;
    if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_zero_height: err_cfg=%b busy=%b, required 1/0", err_cfg, busy);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_abort();
    logic [DW-1:0] d;
    rdy_mode = 2;
    clear_sb();
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_continuous = 1'b0;
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      d = $urandom;
      exp_q.push_back({TB_LINE_LAST && (i % 4 == 0), 4'h5, d});
      send_beat(d, 4'h5, 1'b0);
    end
    s_if.valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    s_if.valid = 1'b1;
    @(negedge aclk);
    vectors++;
    if (busy !== 1'b0 || s_if.ready !== 1'b0 || m_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b s_ready=%b m_valid=%b, required 0/0/0",
               busy, s_if.ready, m_if.valid);
    end
    tick();
    s_if.valid = 1'b0;
    vectors++;
    if (frame_cnt !== 16'(fc_model) || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_cnt: frame_cnt=%0d done=%0d, required %0d/0", frame_cnt, done_cnt, fc_model);
    end
    vectors++;
    if (got_q.size() !== 3) begin
      miscompares++;
      $display("FAIL abort_beat_count: got %0d, required 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_beat%0d: got %h, required %h", i + 1, got_q[i], exp_q[i]);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_midframe();
    rdy_mode = 0;
    cfg_width = 12'd4; cfg_height = 12'd2;
    pulse_start();
    send_beat($urandom, 4'hF, 1'b0);
    send_beat($urandom, 4'hF, 1'b0);
    areset = 1'b1; tick(); areset = 1'b0;
    fc_model = 0;
    @(negedge aclk);
    vectors++;
    if (busy !== 1'b0 || m_if.valid !== 1'b0 || m_if.last !== 1'b0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b m_valid=%b m_last=%b frame_cnt=%0d, required 0/0/0/0",
               busy, m_if.valid, m_if.last, frame_cnt);
    end
    tick();
    s_if.valid = 1'b0;
  endtask

  initial begin
    areset = 1'b1; cfg_width = '0; cfg_height = '0; cfg_continuous = 1'b0;
    start = 1'b0; stop = 1'b0; abort = 1'b0; err_clr = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; s_if.strb = '0; s_if.last = 1'b0;
    m_if.ready = 1'b1;
    test_reset();
    test_single_frame();
    test_short_frame();
    test_long_frame();
    test_continuous();
    test_cfg_err();
    test_abort();
    test_random_frames();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_stream_ctrl.md
# image_stream_ctrl

Frame sequencer for the image stream path. It sits between the slave-stream front end and the skid buffer, and gates beats through only while a frame is armed. It counts column and row against a programmed geometry, regenerates output TLAST at the frame boundary, and flags frames whose upstream TLAST disagrees with the geometry. Geometry, commands and status connect to AXI-Lite register fields.

## Interface
- `DATA_WIDTH`, 32: stream data width; strobe width is DATA_WIDTH/8.
- `DIM_WIDTH`, 12: width of the width, height, column and row fields.
- `FCNT_WIDTH`, 16: frame counter width.
- `aclk` in 1: single clock for all logic.
- `areset` in 1: reset, synchronous, active-high.
- `cfg_width` in DIM_WIDTH: pixels (beats) per line; latched at start.
- `cfg_height` in DIM_WIDTH: lines per frame; latched at start.
- `cfg_continuous` in 1: rearm automatically after each frame; latched at start.
- `start` in 1: one-cycle pulse; honoured only in IDLE.
- `stop` in 1: one-cycle pulse; sets a sticky stop request, honoured at the next frame end.
- `abort` in 1: one-cycle pulse; immediate return to IDLE.
- `err_clr` in 1: one-cycle pulse; clears all error flags.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DATA_WIDTH, `s_strb` in DATA_WIDTH/8, `s_last` in 1: upstream stream.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_WIDTH, `m_strb` out DATA_WIDTH/8, `m_last` out 1: stream toward the skid buffer.
- `busy` out 1: high when the state is not IDLE.
- `frame_done` out 1: one-cycle pulse in DONE.
- `frame_cnt` out FCNT_WIDTH: completed frames; wraps at the maximum value.
- `err_short` out 1: sticky; upstream TLAST arrived before the geometry was complete.
- `err_long` out 1: sticky; geometry completed without upstream TLAST.
- `err_cfg` out 1: sticky; start was issued with a zero width or height.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `s_ready`=0 and `m_valid`=0.
  - On `start`: if width or height is 0, set `err_cfg` and stay in IDLE.
  - Otherwise latch the configuration, clear col, row and the stop request, and go to RUN.
- RUN:
  - Combinational pass-through: `m_valid`=`s_valid`, `s_ready`=`m_ready`, data and strobe routed straight through.
  - A beat transfers when `s_valid`&&`m_ready`.
  - On each transfer, col increments. When col reaches width-1 it wraps to 0 and row increments.
  - Final beat is col==width-1 and row==height-1.
- `m_last` in RUN = (final beat) || `s_last`; `m_last` is therefore never missing at the frame end.
- Transfer with `s_last`=1 before the final beat: set `err_short`, go to DONE.
- Final-beat transfer with `s_last`=1: go to DONE.
- Final-beat transfer with `s_last`=0: set `err_long`, go to FLUSH.
- FLUSH:
  - `s_ready`=1 and `m_valid`=0; upstream beats are discarded.
  - The transfer with `s_last`=1 goes to DONE.
- DONE:
  - Lasts one cycle. Pulse `frame_done`, increment `frame_cnt`, no transfers.
  - If continuous and no stop request: reload col and row to 0, go to RUN.
  - Otherwise go to IDLE.
- `abort` in any state: go to IDLE next cycle. No TLAST is generated, no counter changes, errors are kept. `abort` has priority over the same-cycle transfer's state change; that beat still completes on the bus.
- `start` outside IDLE is ignored.
- `stop` in IDLE has no effect and is not retained.
- `err_clr` and a same-cycle error set: set wins.

## Timing
- Zero-cycle latency in RUN; pure combinational path from s to m.
- Reset values:
  - State IDLE, `s_ready`=0, `m_valid`=0, `m_last`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, all error flags 0.
  - `m_data` and `m_strb` follow the inputs.
- Start to first possible transfer: 1 cycle, since RUN is entered on the next edge.
- Frame end to next frame in continuous mode: 1 idle cycle (DONE).
- Reset mid-frame: immediate IDLE, counters cleared, no TLAST.
- `m_ready` low in RUN: no state or counter change; upstream is stalled.

## Configuration
- Macro `IMAGE_STREAM_CTRL_LINE_LAST_EN`.
- Defined: `m_last` also asserts on every col==width-1 beat (per-line TLAST). Frame-end and error logic are unchanged.
- Undefined: `m_last` asserts only on the frame's final beat or on an early `s_last`.

## Structure
- Package `image_ctrl_pkg`: state enum (IDLE, RUN, FLUSH, DONE), default DIM_WIDTH and FCNT_WIDTH constants.
- Sub-module `image_pos_counter`:
  - Holds the col and row registers.
  - Inputs: advance, clear, width, height.
  - Outputs: col, row, line_end, frame_end flags.

## Test plan
- 4x2 single frame with `m_ready`=1 and upstream TLAST on beat 8 → 8 beats pass, `m_last` only on beat 8, `frame_done` pulse, `frame_cnt`=1, no errors, back to IDLE.
- 4x2 frame with upstream TLAST on beat 5 → `m_last` on beat 5, `err_short`=1, DONE, `frame_cnt`=1.
- 4x2 frame with upstream TLAST on beat 11 → `m_last` on beat 8, `err_long`=1, beats 9–11 absorbed with `m_valid`=0, then DONE.
- Continuous 3x1, `stop` pulsed during frame 2 → exactly 2 frames, 1-cycle gap between them, IDLE after frame 2.
- `start` with width=0 → `err_cfg`=1, `busy` stays 0; then `err_clr` → `err_cfg`=0.
- `m_ready` toggled every cycle plus `abort` after beat 3 of 4x2 → no beat lost or duplicated before the abort, IDLE with `s_ready`=0, `frame_cnt` unchanged.
